// File: rtl/sp_ram_be_pipe.sv
// Single-port synchronous RAM with per-byte write enables, req/ready handshake,
// post-reset clear sweep, selectable write-read return mode and optional output register.
module sp_ram_be_pipe #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned RD_MODE    = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter bit          CLEAR_INIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   data_in,
  output logic                ready,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr, w_clr_ptr_nxt;
  logic                w_clr_en;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_acc, w_wr, w_ret;
  logic [DATA_W-1:0]   w_old, w_merged, w_rdata;
  logic                r_valid;
  logic [DATA_W-1:0]   r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR_INIT ? ST_CLEAR : ST_RUN;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_clr_en      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_en      = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        if (r_clr_ptr == '1) w_state_nxt = ST_RUN;
      end
      ST_RUN:  ;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign ready = (r_state == ST_RUN) && !rst;
  assign w_acc = req && ready;
  assign w_wr  = w_acc && we;
  assign w_old = r_mem[addr];

  always_comb begin
    w_merged = w_old;
    for (int unsigned i = 0; i < NB; i++)
      if (be[i]) w_merged[8*i +: 8] = data_in[8*i +: 8];
  end

  // Writes return data only in READ_FIRST / WRITE_FIRST modes
  assign w_ret   = w_acc && (!we || (RD_MODE != 0));
  assign w_rdata = (we && (RD_MODE == 2)) ? w_merged : w_old;

  // Clear sweep and accepted writes never coincide: ready is low during CLEAR
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr) begin
      for (int unsigned i = 0; i < NB; i++)
        if (be[i]) r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic              r_p_v;
    logic [DATA_W-1:0] r_p_d;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_p_v   <= 1'b0;
        r_p_d   <= '0;
        r_valid <= 1'b0;
        r_dout  <= '0;
      end else begin
        r_p_v   <= w_ret;
        if (w_ret) r_p_d <= w_rdata;
        r_valid <= r_p_v;
        if (r_p_v) r_dout <= r_p_d;
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= 1'b0;
        r_dout  <= '0;
      end else begin
        r_valid <= w_ret;
        if (w_ret) r_dout <= w_rdata;
      end
    end
  end

  assign rd_valid = r_valid;
  assign data_out = r_dout;

  a_req_known: assert property (@(posedge clk) ready |-> !$isunknown({req, we}));

endmodule

// File: tb/tb_sp_ram_be_pipe.sv
// Directed and random checks of sp_ram_be_pipe: three instances sharing stimulus
// (NO_CHANGE, READ_FIRST, WRITE_FIRST+OUT_REG) compared against a behavioural model.
module tb_sp_ram_be_pipe;

  logic        clk, rst, req, we;
  logic [2:0]  addr;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [31:0] dout0, dout1, dout2;

  sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(3), .RD_MODE(0), .OUT_REG(0), .CLEAR_INIT(1'b1)) u_m0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .data_in(data_in),
    .ready(rdy0), .data_out(dout0), .rd_valid(vld0));
  sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(3), .RD_MODE(1), .OUT_REG(0), .CLEAR_INIT(1'b1)) u_m1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .data_in(data_in),
    .ready(rdy1), .data_out(dout1), .rd_valid(vld1));
  sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(3), .RD_MODE(2), .OUT_REG(1), .CLEAR_INIT(1'b1)) u_m2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .data_in(data_in),
    .ready(rdy2), .data_out(dout2), .rd_valid(vld2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_mem [8];
  int unsigned m_clr = 8;
  logic        e0_v = 1'b0, e1_v = 1'b0, e2_v = 1'b0, p2_v = 1'b0;
  logic [31:0] e0_d = '0, e1_d = '0, e2_d = '0, p2_d = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model the edge, then compare every output of every instance
  task automatic step();
    logic        acc;
    logic [31:0] old, mrg;
    logic        rdy;
    acc = req && !rst && (m_clr == 0);
    old = m_mem[addr];
    for (int unsigned i = 0; i < 4; i++)
      mrg[8*i +: 8] = be[i] ? data_in[8*i +: 8] : old[8*i +: 8];
    @(posedge clk);
    if (rst) begin
      m_clr = 8;
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      e0_v = 1'b0; e1_v = 1'b0; e2_v = 1'b0; p2_v = 1'b0;
      e0_d = '0;   e1_d = '0;   e2_d = '0;   p2_d = '0;
    end else begin
      if (m_clr != 0) m_clr--;
      e2_v = p2_v;
      if (p2_v) e2_d = p2_d;
      p2_v = acc;
      if (acc) p2_d = we ? mrg : old;
      e0_v = acc && !we;
      if (e0_v) e0_d = old;
      e1_v = acc;
      if (acc) e1_d = old;
      if (acc && we) m_mem[addr] = mrg;
    end
    #1;
    rdy = (m_clr == 0) && !rst;
    check("m0_ready", 32'(rdy0), 32'(rdy));
    check("m1_ready", 32'(rdy1), 32'(rdy));
    check("m2_ready", 32'(rdy2), 32'(rdy));
    check("m0_valid", 32'(vld0), 32'(e0_v));
    check("m1_valid", 32'(vld1), 32'(e1_v));
    check("m2_valid", 32'(vld2), 32'(e2_v));
    check("m0_data", dout0, e0_d);
    check("m1_data", dout1, e1_d);
    check("m2_data", dout2, e2_d);
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    req = r; we = w; addr = a; be = b; data_in = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);

    // T1: clear sweep, req during CLEAR dropped
    step();
    check("t1_rdy_rst", 32'(rdy0), 32'd0);
    check("t1_dout_rst", dout0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 3'd3, 4'hF, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_rdy", 32'(rdy0), (i == 7) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'(i), 4'h0, 32'h0);
      step();
      check("t1_rd_vld", 32'(vld0), 32'd1);
      check("t1_rd_dat", dout0, 32'h0);
    end

    // T2: byte enables, read-after-write same address
    drive(1'b1, 1'b1, 3'd5, 4'hF, 32'hAABB_CCDD); step();
    drive(1'b1, 1'b1, 3'd5, 4'b0101, 32'h1122_3344); step();
    check("t2_rf_old", dout1, 32'hAABB_CCDD);
    drive(1'b1, 1'b0, 3'd5, 4'h0, 32'h0); step();
    check("t2_vld", 32'(vld0), 32'd1);
    check("t2_dat", dout0, 32'hAA22_CC44);
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0); step();
    check("t2_pulse", 32'(vld0), 32'd0);

    // T3: streaming reads through the OUT_REG instance
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 3'(i), 4'hF, 32'hC0DE_0000 + 32'(i) * 32'h11);
      step();
    end
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0); step();
    step();
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 1'b0, 3'(i), 4'h0, 32'h0);
      step();
      if (i >= 1 && i <= 8) begin
        check("t3_vld", 32'(vld2), 32'd1);
        check("t3_dat", dout2, 32'hC0DE_0000 + 32'(i - 1) * 32'h11);
      end else begin
        check("t3_novld", 32'(vld2), 32'd0);
      end
    end

    // T4: write return data per mode
    drive(1'b1, 1'b1, 3'd2, 4'hF, 32'h0000_FFFF); step();
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0); step();
    drive(1'b1, 1'b1, 3'd2, 4'b1100, 32'h1234_5678); step();
    check("t4_m0_vld", 32'(vld0), 32'd0);
    check("t4_m1_vld", 32'(vld1), 32'd1);
    check("t4_m1_dat", dout1, 32'h0000_FFFF);
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0); step();
    check("t4_m2_vld", 32'(vld2), 32'd1);
    check("t4_m2_dat", dout2, 32'h1234_FFFF);
    drive(1'b1, 1'b0, 3'd2, 4'h0, 32'h0); step();
    check("t4_mem", dout0, 32'h1234_FFFF);

    // T5: reset mid-sweep and with a read in flight
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    rst = 1'b1; step();
    rst = 1'b0; step(); step(); step();
    rst = 1'b1; step();
    check("t5_dout0", dout0, 32'h0);
    check("t5_dout2", dout2, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 3'd4, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5_rdy", 32'(rdy2), (i == 7) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 1'b1, 3'd4, 4'hF, 32'hDEAD_BEEF); step();
    drive(1'b1, 1'b0, 3'd4, 4'h0, 32'h0); step();
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    rst = 1'b1; step();
    check("t5_flush_vld", 32'(vld2), 32'd0);
    check("t5_flush_dat", dout2, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("t5_run", 32'(rdy0), 32'd1);

    // T6: random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(3) != 0, 1'($urandom_range(1)), 3'($urandom_range(7)),
            4'($urandom_range(15)), $urandom);
      step();
    end
    drive(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
